// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing recovery: resynchronises hsync/vsync/pixel, rebuilds the
// pixel position and locks against the nominal timing before emitting qualified pixels.
//
// state  | meaning
// SEARCH | waiting for a vsync leading edge to start qualifying frames
// TRACK  | counting consecutive good frames toward lock
// LOCKED | timing matches; pixels are emitted with position and data enable
module vga_sync_rx #(
    parameter bit HPOL        = 1'b0,
    parameter bit VPOL        = 1'b0,
    parameter int HACTIVE     = 640,
    parameter int HFP         = 16,
    parameter int HSYNCLEN    = 96,
    parameter int HBP         = 48,
    parameter int VACTIVE     = 480,
    parameter int VFP         = 10,
    parameter int VSYNCLEN    = 2,
    parameter int VBP         = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [7:0]  i_pixel,
    output logic [9:0]  o_hcnt,
    output logic [9:0]  o_vcnt,
    output logic [7:0]  o_pixel,
    output logic        o_de,
    output logic        o_frame_start,
    output logic        o_locked,
    output logic [10:0] o_meas_htotal,
    output logic [10:0] o_meas_vtotal,
    output logic [7:0]  o_err_cnt
);

    localparam int HTOTAL = HACTIVE + HFP + HSYNCLEN + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYNCLEN + VBP;

    localparam logic [9:0]  H_LAST = 10'(HTOTAL - 1);
    localparam logic [9:0]  H_LOAD = 10'(HACTIVE + HFP + 1);
    localparam logic [9:0]  H_ACT  = 10'(HACTIVE);
    localparam logic [9:0]  V_LAST = 10'(VTOTAL - 1);
    localparam logic [9:0]  V_LOAD = 10'(VACTIVE + VFP);
    localparam logic [9:0]  V_ACT  = 10'(VACTIVE);
    localparam logic [10:0] H_MEAS = 11'(HTOTAL);
    localparam logic [10:0] V_MEAS = 11'(VTOTAL);
    localparam logic [10:0] H_TMO  = 11'(2 * HTOTAL);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t      state, state_nxt;
    logic        hs_s1, hs_s2, hs_s3, vs_s1, vs_s2, vs_s3;
    logic [7:0]  pix_s1, pix_s2;
    logic        hs_lead, vs_lead;
    logic [9:0]  h_pos, v_pos;
    logic [10:0] line_len, line_len_inc, line_cnt;
    logic        h_valid, h_lost, bad_line, vs_ok, frame_ok;
    logic [3:0]  good;
    logic        frame_bad;
    logic        st_locked, lock_lost, search_entry, de_term;

    // Sync flops idle at the deasserted level so reset release cannot fake an edge.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1  <= !HPOL;
            hs_s2  <= !HPOL;
            hs_s3  <= !HPOL;
            vs_s1  <= !VPOL;
            vs_s2  <= !VPOL;
            vs_s3  <= !VPOL;
            pix_s1 <= '0;
            pix_s2 <= '0;
        end else begin
            hs_s1  <= i_hsync;
            hs_s2  <= hs_s1;
            hs_s3  <= hs_s2;
            vs_s1  <= i_vsync;
            vs_s2  <= vs_s1;
            vs_s3  <= vs_s2;
            pix_s1 <= i_pixel;
            pix_s2 <= pix_s1;
        end
    end

    assign hs_lead = (hs_s2 == HPOL) && (hs_s3 != HPOL);
    assign vs_lead = (vs_s2 == VPOL) && (vs_s3 != VPOL);

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_pos <= '0;
            v_pos <= '0;
        end else begin
            if (hs_lead)
                h_pos <= H_LOAD;
            else if (h_pos >= H_LAST)
                h_pos <= '0;
            else
                h_pos <= h_pos + 10'd1;

            if (vs_lead)
                v_pos <= V_LOAD;
            else if (h_pos >= H_LAST)
                v_pos <= (v_pos >= V_LAST) ? 10'd0 : v_pos + 10'd1;
        end
    end

    assign line_len_inc = (line_len == 11'h7FF) ? line_len : line_len + 11'd1;
    assign h_lost       = (line_len == H_TMO);
    assign bad_line     = hs_lead && h_valid && (line_len_inc != H_MEAS);
    assign vs_ok        = (line_cnt == V_MEAS);
    assign frame_ok     = !frame_bad && !bad_line && !h_lost && vs_ok;
    assign search_entry = (state != SEARCH) && (state_nxt == SEARCH);

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            line_len      <= '0;
            line_cnt      <= '0;
            h_valid       <= 1'b0;
            o_meas_htotal <= '0;
            o_meas_vtotal <= '0;
        end else begin
            if (hs_lead) begin
                o_meas_htotal <= line_len_inc;
                line_len      <= '0;
            end else begin
                line_len <= line_len_inc;
            end

            if (search_entry || h_lost)
                h_valid <= 1'b0;
            else if (hs_lead)
                h_valid <= 1'b1;

            if (vs_lead) begin
                o_meas_vtotal <= line_cnt;
                line_cnt      <= '0;
            end else if (hs_lead && line_cnt != 11'h7FF) begin
                line_cnt <= line_cnt + 11'd1;
            end
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n)
            state <= SEARCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH: if (vs_lead) state_nxt = TRACK;
            TRACK:  if (vs_lead && frame_ok && (good + 4'd1) >= LOCK_N) state_nxt = LOCKED;
            LOCKED: if (bad_line || h_lost || (vs_lead && !vs_ok)) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    always_comb begin
        st_locked = 1'b0;
        lock_lost = 1'b0;
        case (state)
            LOCKED: begin
                st_locked = 1'b1;
                lock_lost = (state_nxt == SEARCH);
            end
            default: ;
        endcase
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            good      <= '0;
            frame_bad <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            case (state)
                SEARCH: if (vs_lead) begin
                    good      <= '0;
                    frame_bad <= 1'b0;
                end
                TRACK: if (vs_lead) begin
                    good      <= frame_ok ? good + 4'd1 : 4'd0;
                    frame_bad <= 1'b0;
                end else if (bad_line || h_lost) begin
                    frame_bad <= 1'b1;
                end
                default: ;
            endcase
            if (lock_lost && o_err_cnt != 8'hFF)
                o_err_cnt <= o_err_cnt + 8'd1;
        end
    end

    assign de_term = st_locked && (h_pos < H_ACT) && (v_pos < V_ACT);

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hcnt        <= '0;
            o_vcnt        <= '0;
            o_de          <= 1'b0;
            o_pixel       <= '0;
            o_frame_start <= 1'b0;
            o_locked      <= 1'b0;
        end else begin
            o_hcnt        <= h_pos;
            o_vcnt        <= v_pos;
            o_de          <= de_term;
            o_pixel       <= de_term ? pix_s2 : 8'd0;
            o_frame_start <= st_locked && (h_pos == 10'd0) && (v_pos == 10'd0);
            o_locked      <= st_locked;
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a reduced timing (25 px x 11 lines per frame)
// so that several lock/unlock sequences fit in a short run.
module tb_vga_sync_rx;

    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b0;

    logic        px_clk;
    logic        rst_n;
    logic        i_hsync, i_vsync;
    logic [7:0]  i_pixel;
    logic [9:0]  o_hcnt, o_vcnt;
    logic [7:0]  o_pixel;
    logic        o_de, o_frame_start, o_locked;
    logic [10:0] o_meas_htotal, o_meas_vtotal;
    logic [7:0]  o_err_cnt;

    vga_sync_rx #(
        .HPOL(HPOL), .VPOL(VPOL),
        .HACTIVE(16), .HFP(2), .HSYNCLEN(4), .HBP(3),
        .VACTIVE(6), .VFP(1), .VSYNCLEN(2), .VBP(2),
        .LOCK_FRAMES(2)
    ) dut (
        .px_clk(px_clk),
        .rst_n(rst_n),
        .i_hsync(i_hsync),
        .i_vsync(i_vsync),
        .i_pixel(i_pixel),
        .o_hcnt(o_hcnt),
        .o_vcnt(o_vcnt),
        .o_pixel(o_pixel),
        .o_de(o_de),
        .o_frame_start(o_frame_start),
        .o_locked(o_locked),
        .o_meas_htotal(o_meas_htotal),
        .o_meas_vtotal(o_meas_vtotal),
        .o_err_cnt(o_err_cnt)
    );

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // source generator state
    int gh, gv, gf, cur_ht, cur_vt, vt_cfg;
    int drv_h, drv_v, drv_f;
    bit gen_en, stretch_req, hs_kill;

    // monitor counters
    int  de_cnt = 0, fs_cnt = 0, pix_bad = 0, fs_bad = 0, unl_bad = 0;
    bit  pix_chk_en = 1'b0;
    int  de_snap, fs_snap, fvar;

    always @(negedge px_clk) begin
        if (rst_n) begin
            if (o_de) de_cnt++;
            if (o_frame_start) fs_cnt++;
            if ((o_de || o_frame_start) && !o_locked) unl_bad++;
            if (pix_chk_en) begin
                if (o_de && o_pixel != o_hcnt[7:0]) pix_bad++;
                if (!o_de && o_pixel != 8'd0) pix_bad++;
                if (o_frame_start && (o_hcnt != 10'd0 || o_vcnt != 10'd0)) fs_bad++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge px_clk);
        #1;
        if (gen_en) begin
            i_hsync = (gh >= 18 && gh < 22 && !hs_kill) ? HPOL : !HPOL;
            i_vsync = (gv >= 7 && gv < 9) ? VPOL : !VPOL;
            i_pixel = 8'(gh);
            drv_h = gh;
            drv_v = gv;
            drv_f = gf;
            if (gh == cur_ht - 1) begin
                gh = 0;
                cur_ht = stretch_req ? 26 : 25;
                stretch_req = 1'b0;
                if (gv == cur_vt - 1) begin
                    gv = 0;
                    gf++;
                    cur_vt = vt_cfg;
                end else begin
                    gv++;
                end
            end else begin
                gh++;
            end
        end else begin
            i_hsync = !HPOL;
            i_vsync = !VPOL;
            i_pixel = 8'd0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pos(input int f, input int l, input int c);
        bit hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            tick();
            hit = (drv_f == f && drv_v == l && drv_h == c);
        end
        n_checks++;
        assert (hit) else begin
            n_fail++;
            $error("FAIL wait_pos: observed not reached expected frame %0d line %0d col %0d", f, l, c);
        end
    endtask

    // Caller drops rst_n first; this holds it, releases it and starts the source at (0,0).
    task automatic restart(input int vt);
        gen_en = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        gh = 0; gv = 0; gf = 0;
        cur_ht = 25; vt_cfg = vt; cur_vt = vt;
        stretch_req = 1'b0; hs_kill = 1'b0;
        gen_en = 1'b1;
    endtask

    task automatic lock_sequence(input string tag);
        wait_pos(1, 7, 0);
        ticks(4);
        chk({tag, "_no_early_lock"}, 64'(o_locked), 64'd0);
        wait_pos(2, 7, 0);
        ticks(3);
        chk({tag, "_lock_edge_minus1"}, 64'(o_locked), 64'd0);
        tick();
        chk({tag, "_lock_edge"}, 64'(o_locked), 64'd1);
        chk({tag, "_meas_htotal"}, 64'(o_meas_htotal), 64'd25);
        chk({tag, "_meas_vtotal"}, 64'(o_meas_vtotal), 64'd11);
        chk({tag, "_err_cnt"}, 64'(o_err_cnt), 64'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        gen_en = 1'b0;
        i_hsync = !HPOL; i_vsync = !VPOL; i_pixel = 8'd0;
        gh = 0; gv = 0; gf = 0; cur_ht = 25; cur_vt = 11; vt_cfg = 11;
        drv_h = -1; drv_v = -1; drv_f = -1;
        stretch_req = 1'b0; hs_kill = 1'b0;
        #3 rst_n = 1'b0;
        ticks(2);
        chk("reset_outputs", {o_hcnt, o_vcnt, o_pixel, o_de, o_frame_start, o_locked,
                              o_meas_htotal, o_meas_vtotal, o_err_cnt}, 64'd0);

        restart(11);
        lock_sequence("first");

        // active pixel at column 5, line 2 and a blanking column on the same line
        wait_pos(3, 2, 5);
        ticks(3);
        chk("pos_active_hcnt", 64'(o_hcnt), 64'd5);
        chk("pos_active_vcnt", 64'(o_vcnt), 64'd2);
        chk("pos_active_de", 64'(o_de), 64'd1);
        chk("pos_active_pixel", 64'(o_pixel), 64'd5);
        wait_pos(3, 2, 20);
        ticks(3);
        chk("pos_blank_hcnt", 64'(o_hcnt), 64'd20);
        chk("pos_blank_de", 64'(o_de), 64'd0);
        chk("pos_blank_pixel", 64'(o_pixel), 64'd0);

        pix_chk_en = 1'b1;
        de_snap = de_cnt;
        fs_snap = fs_cnt;
        ticks(275);
        pix_chk_en = 1'b0;
        chk("de_per_frame", 64'(de_cnt - de_snap), 64'd96);
        chk("fs_per_frame", 64'(fs_cnt - fs_snap), 64'd1);
        chk("pixel_matches_hcnt", 64'(pix_bad), 64'd0);
        chk("frame_start_at_origin", 64'(fs_bad), 64'd0);

        // one 26-cycle line while locked
        fvar = drv_f + 1;
        wait_pos(fvar, 1, 0);
        stretch_req = 1'b1;
        wait_pos(fvar, 3, 18);
        ticks(3);
        chk("stretch_still_locked", 64'(o_locked), 64'd1);
        tick();
        chk("stretch_unlocked", 64'(o_locked), 64'd0);
        chk("stretch_err_cnt", 64'(o_err_cnt), 64'd1);
        wait_pos(fvar + 1, 7, 0);
        ticks(4);
        chk("stretch_relock_not_early", 64'(o_locked), 64'd0);
        wait_pos(fvar + 2, 7, 0);
        ticks(3);
        chk("stretch_relock_minus1", 64'(o_locked), 64'd0);
        tick();
        chk("stretch_relock", 64'(o_locked), 64'd1);

        // hsync missing for three lines
        fvar = fvar + 3;
        wait_pos(fvar, 1, 0);
        hs_kill = 1'b1;
        ticks(72);
        hs_kill = 1'b0;
        ticks(10);
        chk("timeout_unlocked", 64'(o_locked), 64'd0);
        chk("timeout_err_cnt", 64'(o_err_cnt), 64'd2);
        wait_pos(fvar + 3, 0, 0);
        chk("timeout_relock", 64'(o_locked), 64'd1);
        chk("timeout_err_once", 64'(o_err_cnt), 64'd2);

        // asynchronous reset in the middle of a locked frame
        wait_pos(fvar + 3, 3, 5);
        chk("pre_reset_locked", 64'(o_locked), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {o_hcnt, o_vcnt, o_pixel, o_de, o_frame_start, o_locked,
                                    o_meas_htotal, o_meas_vtotal, o_err_cnt}, 64'd0);
        restart(11);
        lock_sequence("after_reset");

        // short frames (one line missing) never lock
        rst_n = 1'b0;
        restart(10);
        de_snap = de_cnt;
        wait_pos(5, 0, 0);
        chk("short_frame_locked", 64'(o_locked), 64'd0);
        chk("short_frame_meas_vtotal", 64'(o_meas_vtotal), 64'd10);
        chk("short_frame_meas_htotal", 64'(o_meas_htotal), 64'd25);
        chk("short_frame_de", 64'(de_cnt - de_snap), 64'd0);
        chk("short_frame_err_cnt", 64'(o_err_cnt), 64'd0);

        chk("de_only_when_locked", 64'(unl_bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
